// File: rtl/uart_rx_frame_deser.sv
//==============================================================================
// Module      : uart_rx_frame_deser
// Description : UART RX frame deserialiser: start, DATA_W data bits, optional
//               parity, 1/2 stop bits; commits word plus error flags.
//               Optional macro UART_RX_DESER_OVERRUN_EN adds data_ack/overrun.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_frame_deser #(
    parameter int DATA_W    = 8,
    parameter int PAR_EN    = 1,
    parameter int PAR_ODD   = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              bit_stb,
    input  logic              sampled_bit,
`ifdef UART_RX_DESER_OVERRUN_EN
    input  logic              data_ack,
    output logic              overrun,
`endif
    output logic [DATA_W-1:0] p_data,
    output logic              data_valid,
    output logic              parity_err,
    output logic              stop_err,
    output logic              busy
);

    localparam logic [3:0] c_LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       c_ODD       = (PAR_ODD != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_par_err, w_par_nxt;
    logic              r_stop_err, w_stop_nxt;
    logic              w_commit;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par_err;
        w_stop_nxt  = r_stop_err;
        w_commit    = 1'b0;
        if (!enable) begin
            // Dropping enable abandons any partial frame without committing it
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_par_nxt   = 1'b0;
            w_stop_nxt  = 1'b0;
        end else if (bit_stb) begin
            case (r_state)
                ST_IDLE: begin
                    if (!sampled_bit) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = 4'd0;
                        w_par_nxt   = 1'b0;
                        w_stop_nxt  = 1'b0;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt = {sampled_bit, r_shift[DATA_W-1:1]};
                    if (r_cnt == c_LAST_DATA) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    w_par_nxt   = (^r_shift) ^ sampled_bit ^ c_ODD;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_stop_nxt = r_stop_err | ~sampled_bit;
                    if (r_cnt == c_LAST_STOP) begin
                        w_commit    = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= 4'd0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_par_err  <= w_par_nxt;
            r_stop_err <= w_stop_nxt;
            data_valid <= w_commit;
            if (w_commit) begin
                p_data     <= r_shift;
                parity_err <= w_par_nxt;
                stop_err   <= w_stop_nxt;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

`ifdef UART_RX_DESER_OVERRUN_EN
    logic r_pending;

    // An ack in the commit cycle retires the old word, so it is not an overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_commit && r_pending && !data_ack) begin
                overrun <= 1'b1;
            end
            if (w_commit) begin
                r_pending <= 1'b1;
            end else if (data_ack) begin
                r_pending <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_deser.sv
//==============================================================================
// Module      : tb_uart_rx_frame_deser
// Description : Self-checking bench for uart_rx_frame_deser, three configs,
//               randomized frames against a frame-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_frame_deser;

    typedef bit bitq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en   [3];
    logic       stb  [3];
    logic       sbit [3];
    logic       dv   [3];
    logic       perr [3];
    logic       serr [3];
    logic       bsy  [3];
    logic [7:0] pd0;
    logic [6:0] pd1;
    logic [7:0] pd2;
`ifdef UART_RX_DESER_OVERRUN_EN
    logic       ack  [3];
    logic       ovr  [3];
`endif

    // Per-instance configuration: {DATA_W, PAR_EN, PAR_ODD, STOP_BITS}
    int c_DW [3] = '{8, 7, 8};
    int c_PE [3] = '{1, 1, 0};
    int c_PO [3] = '{0, 1, 0};
    int c_SB [3] = '{1, 2, 2};

    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          vcnt [3] = '{0, 0, 0};
    int          exp_pulses [3] = '{0, 0, 0};
    logic [8:0]  last_pd [3] = '{9'd0, 9'd0, 9'd0};

    uart_rx_frame_deser #(.DATA_W(8), .PAR_EN(1), .PAR_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .bit_stb(stb[0]), .sampled_bit(sbit[0]),
`ifdef UART_RX_DESER_OVERRUN_EN
        .data_ack(ack[0]), .overrun(ovr[0]),
`endif
        .p_data(pd0), .data_valid(dv[0]), .parity_err(perr[0]), .stop_err(serr[0]), .busy(bsy[0])
    );

    uart_rx_frame_deser #(.DATA_W(7), .PAR_EN(1), .PAR_ODD(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .bit_stb(stb[1]), .sampled_bit(sbit[1]),
`ifdef UART_RX_DESER_OVERRUN_EN
        .data_ack(ack[1]), .overrun(ovr[1]),
`endif
        .p_data(pd1), .data_valid(dv[1]), .parity_err(perr[1]), .stop_err(serr[1]), .busy(bsy[1])
    );

    uart_rx_frame_deser #(.DATA_W(8), .PAR_EN(0), .PAR_ODD(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en[2]), .bit_stb(stb[2]), .sampled_bit(sbit[2]),
`ifdef UART_RX_DESER_OVERRUN_EN
        .data_ack(ack[2]), .overrun(ovr[2]),
`endif
        .p_data(pd2), .data_valid(dv[2]), .parity_err(perr[2]), .stop_err(serr[2]), .busy(bsy[2])
    );

    always @(posedge clk) begin
        if (dv[0]) vcnt[0] <= vcnt[0] + 1;
        if (dv[1]) vcnt[1] <= vcnt[1] + 1;
        if (dv[2]) vcnt[2] <= vcnt[2] + 1;
    end

    function automatic logic [8:0] get_pd(int w);
        case (w)
            0:       return {1'b0, pd0};
            1:       return {2'b0, pd1};
            default: return {1'b0, pd2};
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line-level frame: start, data LSB first, optional parity, stop bit(s)
    function automatic bitq_t build_frame(int w, logic [8:0] d, bit pbit, bit s0, bit s1);
        bitq_t q;
        q.push_back(1'b0);
        for (int i = 0; i < c_DW[w]; i++) q.push_back(d[i]);
        if (c_PE[w] != 0) q.push_back(pbit);
        q.push_back(s0);
        if (c_SB[w] == 2) q.push_back(s1);
        return q;
    endfunction

    // Called on a negedge; leaves the caller on the negedge after the strobe
    task automatic strobe(int w, bit b, int gap);
        repeat (gap) @(negedge clk);
        stb[w]  = 1'b1;
        sbit[w] = b;
        @(negedge clk);
        stb[w]  = 1'b0;
        sbit[w] = 1'b1;
    endtask

    task automatic expect_commit(int w, logic [8:0] d, bit pbit, bit s0, bit s1);
        int          ones;
        logic [8:0]  mask;
        ones = 0;
        mask = 9'((1 << c_DW[w]) - 1);
        for (int i = 0; i < c_DW[w]; i++) ones += int'(d[i]);
        exp_pulses[w]++;
        last_pd[w] = d & mask;
        check($sformatf("valid_lat%0d", w), 32'(dv[w]), 32'd1);
        check($sformatf("p_data%0d", w), 32'(get_pd(w)), 32'(d & mask));
        check($sformatf("parity_err%0d", w), 32'(perr[w]),
              (c_PE[w] != 0) ? 32'(((ones + int'(pbit) + c_PO[w]) % 2) != 0) : 32'd0);
        check($sformatf("stop_err%0d", w), 32'(serr[w]), 32'((!s0) || (c_SB[w] == 2 && !s1)));
        check($sformatf("busy_after%0d", w), 32'(bsy[w]), 32'd0);
    endtask

    task automatic send_frame(int w, logic [8:0] d, bit pbit, bit s0, bit s1, int maxgap);
        bitq_t q;
        q = build_frame(w, d, pbit, s0, s1);
        foreach (q[k]) strobe(w, q[k], $urandom_range(0, maxgap));
        expect_commit(w, d, pbit, s0, s1);
    endtask

    task automatic check_pulses(string tag);
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++)
            check($sformatf("%s_pulses%0d", tag, w), 32'(vcnt[w]), 32'(exp_pulses[w]));
    endtask

    task automatic partial_frame(int w);
        strobe(w, 1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(w, 1'($urandom_range(0, 1)), 0);
        check("busy_mid", 32'(bsy[w]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int w = 0; w < 3; w++) begin
            en[w] = 1'b1; stb[w] = 1'b0; sbit[w] = 1'b1;
`ifdef UART_RX_DESER_OVERRUN_EN
            ack[w] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            check("rst_p_data", 32'(get_pd(w)), 32'd0);
            check("rst_valid", 32'(dv[w]), 32'd0);
            check("rst_perr", 32'(perr[w]), 32'd0);
            check("rst_serr", 32'(serr[w]), 32'd0);
            check("rst_busy", 32'(bsy[w]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed frames
        send_frame(2, 9'h0A5, 1'b0, 1'b1, 1'b1, 2);
        send_frame(0, 9'h003, 1'b1, 1'b1, 1'b1, 1);
        send_frame(0, 9'h003, 1'b0, 1'b1, 1'b1, 0);
        send_frame(2, 9'h05A, 1'b0, 1'b1, 1'b0, 1);
        send_frame(1, 9'h07F, 1'b0, 1'b1, 1'b1, 1);

        // Idle-line strobes in IDLE must not start a frame
        for (int i = 0; i < 5; i++) begin
            strobe(0, 1'b1, $urandom_range(0, 2));
            check("glitch_busy", 32'(bsy[0]), 32'd0);
        end
        send_frame(0, 9'h03C, 1'b0, 1'b1, 1'b1, 1);
        check_pulses("directed");

        // Enable drop mid-frame drops the partial frame
        partial_frame(0);
        en[0] = 1'b0;
        @(negedge clk);
        en[0] = 1'b1;
        check("abort_busy", 32'(bsy[0]), 32'd0);
        check("abort_hold", 32'(get_pd(0)), 32'(last_pd[0]));
        send_frame(0, 9'h081, 1'b0, 1'b1, 1'b1, 1);
        check_pulses("abort");

        // Reset mid-frame restores all reset values
        partial_frame(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_p_data", 32'(get_pd(0)), 32'd0);
        check("rstmid_perr", 32'(perr[0]), 32'd0);
        check("rstmid_serr", 32'(serr[0]), 32'd0);
        check("rstmid_busy", 32'(bsy[0]), 32'd0);
        check("rstmid_valid", 32'(dv[0]), 32'd0);
        for (int w = 0; w < 3; w++) last_pd[w] = 9'd0;

        // Randomized frames, including back-to-back starts and idle glitches
        for (int n = 0; n < 25; n++) begin
            for (int w = 0; w < 3; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) strobe(w, 1'b1, $urandom_range(0, 1));
                    check("rnd_glitch_busy", 32'(bsy[w]), 32'd0);
                end
                send_frame(w, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                           (n % 3 == 0) ? 0 : 3);
            end
        end
        check_pulses("random");

`ifdef UART_RX_DESER_OVERRUN_EN
        begin
            bitq_t q;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("ovr_rst", 32'(ovr[0]), 32'd0);
            send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1, 1);
            check("ovr_first", 32'(ovr[0]), 32'd0);
            q = build_frame(0, 9'h022, 1'b0, 1'b1, 1'b1);
            for (int k = 0; k < q.size(); k++) begin
                if (k == q.size() - 1) ack[0] = 1'b1;
                strobe(0, q[k], 0);
                ack[0] = 1'b0;
            end
            expect_commit(0, 9'h022, 1'b0, 1'b1, 1'b1);
            check("ovr_ack_same", 32'(ovr[0]), 32'd0);
            send_frame(0, 9'h044, 1'b0, 1'b1, 1'b1, 1);
            check("ovr_set", 32'(ovr[0]), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame_deser.md
Name: uart_rx_frame_deser

Overview:
- Parametrised successor to the UART RX serial-to-parallel stage.
- Receives one mid-bit sampled value per bit period from the data sampler, qualified by a one-cycle strobe.
- Owns its own frame FSM: start, configurable data width, optional parity, 1 or 2 stop bits.
- Presents a parallel word with a one-cycle valid pulse plus per-frame parity and framing error flags to the RX controller and ALU command path.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- PAR_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PAR_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PAR_EN = 0.
- STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.

Ports:
- clk  input  1  block clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- enable  input  1  receiver enable; low forces IDLE.
- bit_stb  input  1  one-cycle pulse: sampled_bit is valid this cycle.
- sampled_bit  input  1  majority-voted line value for the current bit.
- p_data  output  DATA_W  last received word, LSB = first data bit.
- data_valid  output  1  one-cycle pulse: p_data and the error flags were updated.
- parity_err  output  1  parity mismatch on the last frame; 0 when PAR_EN = 0.
- stop_err  output  1  at least one stop bit was sampled 0 on the last frame.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset: p_data = 0, data_valid = 0, parity_err = 0, stop_err = 0, busy = 0, FSM = IDLE, shift register = 0, bit counter = 0.
- States and transitions (all only on cycles where bit_stb = 1, unless noted):
  - IDLE: sampled_bit = 0 → DATA with counter cleared. sampled_bit = 1 → stay in IDLE (glitch or idle line).
  - DATA: shift sampled_bit into the MSB of the shift register, shifting right, so the first bit ends in bit 0. Increment counter. On the DATA_W-th bit → PARITY if PAR_EN = 1, else STOP.
  - PARITY: latch the mismatch internally. Mismatch is (XOR of data bits) XOR sampled_bit XOR PAR_ODD ≠ 0. Go to STOP.
  - STOP: accumulate an internal stop-error flag if sampled_bit = 0. After STOP_BITS strobes → IDLE, and commit the frame.
- Commit: at the same clock edge that samples the final stop bit:
  - p_data ← shift register;
  - parity_err and stop_err ← the internal flags;
  - data_valid = 1 for exactly the next cycle.
- Latency: data_valid is high in the cycle immediately after the final stop-bit strobe.
- Frames with errors still commit and still pulse data_valid; the consumer decides whether to discard.
- p_data and the error flags hold their values until the next commit.
- bit_stb = 0: no state change except data_valid returning to 0.
- enable low on any edge, including mid-frame:
  - FSM → IDLE, counter and internal flags cleared;
  - no commit, so a partial frame is dropped;
  - p_data and the error flags keep their last committed values.
- rst mid-frame: full reset values as listed above; rst has priority over enable and bit_stb.
- Back-to-back frames: a start bit strobe in the cycle after a commit is accepted. The IDLE state needs no dead cycle.
- busy = 1 in DATA, PARITY and STOP.

Optional Feature:
- Macro: UART_RX_DESER_OVERRUN_EN.
- Defined: adds input `data_ack` (1 bit) and output `overrun` (1 bit, reset 0).
  - An internal pending flag sets on commit and clears on data_ack = 1.
  - If a commit occurs while pending = 1 and data_ack = 0 in that cycle, overrun = 1 sticky until rst. p_data is still overwritten.
  - A simultaneous commit and data_ack is not an overrun.
- Undefined: neither port exists, no pending logic is built, and behaviour is as above.

Test Plan:
- Defaults, PAR_EN = 0. Frame start 0, data 0xA5 LSB-first, stop 1 → one data_valid pulse, p_data = 0xA5, parity_err = 0, stop_err = 0, busy low after commit.
- PAR_EN = 1, even parity. Data 0x03 with parity bit 1 → p_data = 0x03, parity_err = 1. Next frame 0x03 with parity bit 0 → parity_err = 0.
- STOP_BITS = 2. Data 0x5A, stop bits 1 then 0 → data_valid pulses, p_data = 0x5A, stop_err = 1.
- IDLE with bit_stb and sampled_bit = 1 for 5 strobes → busy stays 0, no data_valid. Then a valid frame 0x3C → p_data = 0x3C.
- After 4 data bits, enable = 0 for 1 cycle, then re-enable and send 0x81 → exactly one data_valid, p_data = 0x81. Repeat with rst high mid-frame → all outputs 0.
- DATA_W = 7, PAR_ODD = 1. Data 0x7F with parity bit 0 → p_data = 0x7F, parity_err = 0. With UART_RX_DESER_OVERRUN_EN defined, two commits without data_ack → overrun = 1.
